// File: rtl/div_arbiter.sv
// div_arbiter: two requesters share one restoring divider with round-robin
// arbitration. Only one division is in flight at a time.
//
// Ports:
//   clock, reset              rising-edge clock, synchronous active-high reset
//   reqN_valid / reqN_ready   request handshake for requester N (0 or 1)
//   reqN_a / reqN_b           dividend / divisor of requester N
//   resp_valid / resp_ready   result handshake
//   resp_id                   requester that owns the result
//   resp_q / resp_r           quotient / remainder
//   resp_div0                 divisor was zero (q = all ones, r = dividend)
//   busy                      FSM is not idle
module div_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_q,
    output logic [WIDTH-1:0] resp_r,
    output logic             resp_div0,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic             ptr;        // requester that wins the next tie
    logic             op_id;      // owner of the division in flight
    logic [CW-1:0]    cnt;        // bit index of the current iteration
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] qreg;       // dividend bits shift out, quotient bits fill in
    logic [WIDTH:0]   rem;        // one extra bit so shift/compare never overflow

    logic             gnt;
    logic             gnt_valid;
    logic             idle_open;
    logic             accept;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] q_next;
    logic             ge;

    // Grant: a lone requester wins; on a tie the pointer decides.
    always_comb begin
        gnt = 1'b0;
        if (req0_valid && req1_valid) begin
            gnt = ptr;
        end else if (req1_valid) begin
            gnt = 1'b1;
        end
        gnt_valid = req0_valid | req1_valid;
        sel_a     = gnt ? req1_a : req0_a;
        sel_b     = gnt ? req1_b : req0_b;
    end

    assign idle_open  = (state == IDLE) && !reset;
    assign req0_ready = idle_open && !gnt;
    assign req1_ready = idle_open && gnt;
    assign accept     = idle_open && gnt_valid;
    assign busy       = (state != IDLE);

    // One restoring step: bring down the next dividend bit, subtract if it fits.
    always_comb begin
        rem_sh      = (rem << 1) | {{WIDTH{1'b0}}, qreg[cnt]};
        ge          = (rem_sh >= {1'b0, divisor});
        rem_next    = ge ? (rem_sh - {1'b0, divisor}) : rem_sh;
        q_next      = qreg;
        q_next[cnt] = ge;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= 1'b0;
            op_id      <= 1'b0;
            cnt        <= CW'(WIDTH - 1);
            divisor    <= '0;
            qreg       <= '0;
            rem        <= '0;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_q     <= '0;
            resp_r     <= '0;
            resp_div0  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        ptr   <= ~gnt;
                        op_id <= gnt;
                        if (sel_b == '0) begin
                            // Divide by zero completes immediately.
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            resp_id    <= gnt;
                            resp_q     <= '1;
                            resp_r     <= sel_a;
                            resp_div0  <= 1'b1;
                        end else begin
                            state   <= ITER;
                            cnt     <= CW'(WIDTH - 1);
                            rem     <= '0;
                            qreg    <= sel_a;
                            divisor <= sel_b;
                        end
                    end
                end
                ITER: begin
                    rem  <= rem_next;
                    qreg <= q_next;
                    cnt  <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state      <= DONE;
                        cnt        <= CW'(WIDTH - 1);
                        resp_valid <= 1'b1;
                        resp_id    <= op_id;
                        resp_q     <= q_next;
                        resp_r     <= rem_next[WIDTH-1:0];
                        resp_div0  <= 1'b0;
                    end
                end
                DONE: begin
                    // Returning to IDLE leaves a bubble before the next accept.
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter (WIDTH = 32): directed scenarios plus a
// randomized two-requester stream scored against a plain arithmetic model.
module tb_div_arbiter;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset;
    logic         req0_valid, req0_ready;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready;
    logic [W-1:0] req1_a, req1_b;
    logic         resp_valid, resp_ready, resp_id, resp_div0, busy;
    logic [W-1:0] resp_q, resp_r;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic         id;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         div0;
    } exp_t;

    div_arbiter #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_q(resp_q), .resp_r(resp_r), .resp_div0(resp_div0), .busy(busy)
    );

    always #5 clock = ~clock;

    // Reference arithmetic: divide-by-zero yields all ones and the dividend.
    function automatic logic [W-1:0] mq(input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == '0) ? '1 : a / b;
    endfunction

    function automatic logic [W-1:0] mr(input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == '0) ? a : a % b;
    endfunction

    function automatic logic [W-1:0] rand_b();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return 32'd1;
            default: return $urandom >> $urandom_range(0, 31);
        endcase
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Returns the number of edges until resp_valid is seen (-1 on timeout).
    task automatic wait_resp(output int cyc);
        cyc = -1;
        for (int n = 0; n <= 100; n++) begin
            if (resp_valid) begin
                cyc = n;
                break;
            end
            step();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b0;
        req0_a = 32'd5; req0_b = 32'd1; req1_a = 32'd6; req1_b = 32'd2;
        step(); step();
        checks++;
        if ({busy, resp_valid, resp_div0, resp_id} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 0000", {busy, resp_valid, resp_div0, resp_id});
        end
        checks++;
        if (resp_q !== '0 || resp_r !== '0) begin
            errors++; $display("FAIL reset_data: got q=%0h r=%0h expected 0 0", resp_q, resp_r);
        end
        checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            errors++; $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready});
        end
        reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int cyc;
        resp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd100; req0_b = 32'd7;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++; $display("FAIL basic_ready: got %b expected 10", {req0_ready, req1_ready});
        end
        step();
        // Operands changed after accept must be ignored.
        req0_valid = 1'b0; req0_a = 32'd999; req0_b = 32'd1;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL basic_busy: got %b expected 1", busy);
        end
        wait_resp(cyc);
        checks++;
        if (cyc != W) begin
            errors++; $display("FAIL basic_latency: got %0d expected %0d", cyc, W);
        end
        checks++;
        if ({resp_id, resp_q, resp_r, resp_div0} !== {1'b0, 32'd14, 32'd2, 1'b0}) begin
            errors++; $display("FAIL basic_result: got id=%0d q=%0d r=%0d d0=%0d expected id=0 q=14 r=2 d0=0",
                               resp_id, resp_q, resp_r, resp_div0);
        end
        step();
        checks++;
        if ({resp_valid, busy} !== 2'b00) begin
            errors++; $display("FAIL basic_release: got %b expected 00", {resp_valid, busy});
        end
    endtask

    task automatic test_tie();
        int cyc;
        do_reset();
        resp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd3;
        req1_valid = 1'b1; req1_a = 32'd20; req1_b = 32'd6;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++; $display("FAIL tie_first_grant: got %b expected 10", {req0_ready, req1_ready});
        end
        step();
        req0_valid = 1'b0;
        wait_resp(cyc);
        checks++;
        if ({resp_id, resp_q, resp_r} !== {1'b0, 32'd3, 32'd1} || cyc != W) begin
            errors++; $display("FAIL tie_first_result: got id=%0d q=%0d r=%0d cyc=%0d expected id=0 q=3 r=1 cyc=%0d",
                               resp_id, resp_q, resp_r, cyc, W);
        end
        checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            errors++; $display("FAIL tie_done_ready: got %b expected 00", {req0_ready, req1_ready});
        end
        step();
        checks++;
        if (req1_ready !== 1'b1) begin
            errors++; $display("FAIL tie_second_ready: got %b expected 1", req1_ready);
        end
        step();
        req1_valid = 1'b0;
        wait_resp(cyc);
        checks++;
        if ({resp_id, resp_q, resp_r, resp_div0} !== {1'b1, 32'd3, 32'd2, 1'b0}) begin
            errors++; $display("FAIL tie_second_result: got id=%0d q=%0d r=%0d expected id=1 q=3 r=2",
                               resp_id, resp_q, resp_r);
        end
        step();
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++; $display("FAIL tie_next_grant: got %b expected 10", {req0_ready, req1_ready});
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_boundary();
        logic [W-1:0] ta [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1};
        logic [W-1:0] tb [4] = '{32'h8000_0000, 32'd1, 32'h8000_0001, 32'hFFFF_FFFF};
        logic [W-1:0] eq [4] = '{32'd1, 32'hFFFF_FFFF, 32'd1, 32'd0};
        logic [W-1:0] er [4] = '{32'h7FFF_FFFF, 32'd0, 32'h7FFF_FFFE, 32'd1};
        int cyc;
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req0_valid = 1'b1; req0_a = ta[i]; req0_b = tb[i];
            step();
            req0_valid = 1'b0;
            wait_resp(cyc);
            checks++;
            if ({resp_q, resp_r, resp_div0} !== {eq[i], er[i], 1'b0} || cyc != W) begin
                errors++; $display("FAIL boundary_%0d: got q=%0h r=%0h d0=%0d cyc=%0d expected q=%0h r=%0h d0=0 cyc=%0d",
                                   i, resp_q, resp_r, resp_div0, cyc, eq[i], er[i], W);
            end
            step();
        end
    endtask

    task automatic test_div0();
        int cyc;
        resp_ready = 1'b1;
        req1_valid = 1'b1; req1_a = 32'd55; req1_b = 32'd0;
        #1;
        checks++;
        if (req1_ready !== 1'b1) begin
            errors++; $display("FAIL div0_ready: got %b expected 1", req1_ready);
        end
        step();
        req1_valid = 1'b0;
        wait_resp(cyc);
        checks++;
        if (cyc != 0) begin
            errors++; $display("FAIL div0_latency: got %0d expected 0", cyc);
        end
        checks++;
        if ({resp_id, resp_q, resp_r, resp_div0} !== {1'b1, 32'hFFFF_FFFF, 32'd55, 1'b1}) begin
            errors++; $display("FAIL div0_result: got id=%0d q=%0h r=%0d d0=%0d expected id=1 q=ffffffff r=55 d0=1",
                               resp_id, resp_q, resp_r, resp_div0);
        end
        step();
    endtask

    task automatic test_backpressure();
        int cyc;
        int bad = 0;
        resp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd50; req0_b = 32'd6;
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 32'd77; req1_b = 32'd5;
        wait_resp(cyc);
        for (int i = 0; i < 10; i++) begin
            if ({resp_valid, resp_id, resp_q, resp_r, resp_div0, req0_ready, req1_ready}
                !== {1'b1, 1'b0, 32'd8, 32'd2, 1'b0, 1'b0, 1'b0}) bad++;
            step();
        end
        checks++;
        if (bad != 0 || cyc != W) begin
            errors++; $display("FAIL hold_stable: got %0d unstable cycles cyc=%0d expected 0 cyc=%0d", bad, cyc, W);
        end
        resp_ready = 1'b1;
        step();
        checks++;
        if ({resp_valid, busy, req1_ready} !== 3'b001) begin
            errors++; $display("FAIL hold_bubble: got %b expected 001", {resp_valid, busy, req1_ready});
        end
        step();
        req1_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL hold_accept: got busy=%b expected 1", busy);
        end
        wait_resp(cyc);
        checks++;
        if ({resp_id, resp_q, resp_r} !== {1'b1, 32'd15, 32'd2}) begin
            errors++; $display("FAIL hold_waiter: got id=%0d q=%0d r=%0d expected id=1 q=15 r=2",
                               resp_id, resp_q, resp_r);
        end
        step();
    endtask

    task automatic test_reset_abort();
        int cyc;
        int seen = 0;
        resp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd1000; req0_b = 32'd3;
        step();
        req0_valid = 1'b0;
        for (int i = 0; i < 16; i++) step();
        reset = 1'b1;
        step();
        checks++;
        if ({busy, resp_valid, resp_id, resp_div0, req0_ready, req1_ready} !== 6'b0) begin
            errors++; $display("FAIL abort_ctrl: got %b expected 000000",
                               {busy, resp_valid, resp_id, resp_div0, req0_ready, req1_ready});
        end
        checks++;
        if (resp_q !== '0 || resp_r !== '0) begin
            errors++; $display("FAIL abort_data: got q=%0h r=%0h expected 0 0", resp_q, resp_r);
        end
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (resp_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL abort_no_resp: got %0d valid cycles expected 0", seen);
        end
        req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd2;
        step();
        req0_valid = 1'b0;
        wait_resp(cyc);
        checks++;
        if ({resp_q, resp_r, resp_id} !== {32'd4, 32'd1, 1'b0} || cyc != W) begin
            errors++; $display("FAIL abort_fresh: got q=%0d r=%0d id=%0d cyc=%0d expected q=4 r=1 id=0 cyc=%0d",
                               resp_q, resp_r, resp_id, cyc, W);
        end
        step();
    endtask

    task automatic test_back_to_back();
        exp_t expq[$];
        int   nacc = 0;
        int   last_acc = -1;
        bit   renew = 1'b0;
        resp_ready = 1'b1;
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_a = $urandom; req0_b = rand_b() | 32'd1;
        #1;
        for (int k = 0; k < 400; k++) begin
            if (renew) begin
                renew = 1'b0;
                if (nacc == 5) req0_valid = 1'b0;
                req0_a = $urandom; req0_b = rand_b() | 32'd1;
                #1;
            end
            if (resp_valid) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++; $display("FAIL b2b_spurious: got unexpected response q=%0h", resp_q);
                end else begin
                    if ({resp_id, resp_q, resp_r, resp_div0} !== expq[0]) begin
                        errors++; $display("FAIL b2b_result: got q=%0h r=%0h expected q=%0h r=%0h",
                                           resp_q, resp_r, expq[0].q, expq[0].r);
                    end
                    void'(expq.pop_front());
                end
            end
            if (req0_valid && req0_ready) begin
                expq.push_back('{1'b0, mq(req0_a, req0_b), mr(req0_a, req0_b), 1'b0});
                if (last_acc >= 0) begin
                    checks++;
                    if (k - last_acc != W + 2) begin
                        errors++; $display("FAIL b2b_spacing: got %0d expected %0d", k - last_acc, W + 2);
                    end
                end
                last_acc = k;
                nacc++;
                renew = 1'b1;
            end
            if (nacc == 5 && !renew && expq.size() == 0 && !req0_valid) break;
            step();
        end
        checks++;
        if (nacc != 5 || expq.size() != 0) begin
            errors++; $display("FAIL b2b_count: got %0d accepts %0d pending expected 5 0", nacc, expq.size());
        end
        req0_valid = 1'b0;
    endtask

    task automatic test_random();
        exp_t expq[$];
        logic last = 1'b1;   // after reset a tie favours requester 0
        logic g;
        bit   acc0 = 1'b0, acc1 = 1'b0;
        do_reset();
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            step();
            if (acc0) begin req0_valid = 1'b0; acc0 = 1'b0; end
            if (acc1) begin req1_valid = 1'b0; acc1 = 1'b0; end
            if (k < 2500 && !req0_valid && $urandom_range(0, 3) == 0) begin
                req0_valid = 1'b1; req0_a = $urandom >> $urandom_range(0, 16); req0_b = rand_b();
            end
            if (k < 2500 && !req1_valid && $urandom_range(0, 3) == 0) begin
                req1_valid = 1'b1; req1_a = $urandom >> $urandom_range(0, 16); req1_b = rand_b();
            end
            resp_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (expq.size() != 0) begin
                if (req0_ready || req1_ready) begin
                    checks++; errors++;
                    $display("FAIL rand_busy_ready: got %b expected 00", {req0_ready, req1_ready});
                end
            end else if (req0_valid || req1_valid) begin
                g = (req0_valid && req1_valid) ? ~last : req1_valid;
                checks++;
                if ({req0_ready, req1_ready} !== (g ? 2'b01 : 2'b10)) begin
                    errors++; $display("FAIL rand_grant: got %b expected %b", {req0_ready, req1_ready}, g ? 2'b01 : 2'b10);
                end
                if (g) expq.push_back('{1'b1, mq(req1_a, req1_b), mr(req1_a, req1_b), req1_b == '0});
                else   expq.push_back('{1'b0, mq(req0_a, req0_b), mr(req0_a, req0_b), req0_b == '0});
                last = g;
                if (g) acc1 = 1'b1; else acc0 = 1'b1;
            end
            if (resp_valid) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++; $display("FAIL rand_spurious: got unexpected response id=%0d", resp_id);
                end else begin
                    if ({resp_id, resp_q, resp_r, resp_div0} !== expq[0]) begin
                        errors++; $display("FAIL rand_result: got id=%0d q=%0h r=%0h d0=%0d expected id=%0d q=%0h r=%0h d0=%0d",
                                           resp_id, resp_q, resp_r, resp_div0,
                                           expq[0].id, expq[0].q, expq[0].r, expq[0].div0);
                    end
                    if (resp_ready) void'(expq.pop_front());
                end
            end
        end
        checks++;
        if (expq.size() != 0 || req0_valid || req1_valid) begin
            errors++; $display("FAIL rand_drain: got %0d pending v0=%0d v1=%0d expected 0 0 0",
                               expq.size(), req0_valid, req1_valid);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; resp_ready = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0;
        test_reset();
        test_basic();
        test_tie();
        test_boundary();
        test_div0();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
